// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory command scheduler.
// Holds the DRAM command encoding, scheduler FSM states and the latched request record.
// MEM_CMD_SCHED_CLOSED_PAGE_EN adds the AUTO_PRE state.
package mem_ctrl_pkg;

  // Default geometry. sched_req_t is sized from these, so the scheduler's
  // geometry parameters must be kept equal to them.
  localparam int ROW_W = 8;
  localparam int COL_W = 4;
  localparam int BG_W  = 2;
  localparam int BA_W  = 1;

  typedef enum logic [2:0] {
    CMD_READ      = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_PRECHARGE = 3'd3
  } cmd_e;

  // S_IDLE must encode as zero; it is the reset state.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_PRE,
    S_ACT,
    S_WAIT_ACT,
    S_COL
`ifdef MEM_CMD_SCHED_CLOSED_PAGE_EN
    , S_AUTO_PRE
`endif
  } sched_state_e;

  typedef struct packed {
    logic              write;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [BG_W-1:0]   bg;
    logic [BA_W-1:0]   ba;
    logic [7:0][63:0]  data;
  } sched_req_t;

endpackage

// File: rtl/address_parser.sv
// Splits a physical request address into DRAM fields, LSB up: col, bank, bank group, row.
// Latency: purely combinational.
// Backpressure: none.
// Ports: addr in; col, ba, bg, row out. Address bits above the row field are ignored.
module address_parser #(
  parameter int PADDR_BITS = 19,
  parameter int COL_BITS   = 4,
  parameter int BA_BITS    = 1,
  parameter int BG_BITS    = 2,
  parameter int ROW_BITS   = 8
) (
  input  logic [PADDR_BITS-1:0] addr,
  output logic [COL_BITS-1:0]   col,
  output logic [BA_BITS-1:0]    ba,
  output logic [BG_BITS-1:0]    bg,
  output logic [ROW_BITS-1:0]   row
);
  localparam int BA_LSB  = COL_BITS;
  localparam int BG_LSB  = BA_LSB + BA_BITS;
  localparam int ROW_LSB = BG_LSB + BG_BITS;
  localparam int TOP     = ROW_LSB + ROW_BITS;

  assign col = addr[BA_LSB-1:0];
  assign ba  = addr[BG_LSB-1:BA_LSB];
  assign bg  = addr[ROW_LSB-1:BG_LSB];
  assign row = addr[TOP-1:ROW_LSB];

  // Spare high address bits carry no DRAM meaning.
  logic unused_hi;
  assign unused_hi = ^addr[PADDR_BITS-1:TOP];
endmodule

// File: rtl/bank_state_table.sv
// Per-bank open-row table: one open bit and one row per {bank_group, bank} entry.
// Latency: lookup is combinational; an update is visible the cycle after it is applied.
// Backpressure: none. Ports: lookup (lkp_idx -> lkp_open/lkp_row); update (upd_en/upd_idx/upd_open/upd_row).
module bank_state_table #(
  parameter int ENTRIES  = 8,
  parameter int IDX_W    = 3,
  parameter int ROW_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    lkp_idx,
  output logic                lkp_open,
  output logic [ROW_BITS-1:0] lkp_row,
  input  logic                upd_en,
  input  logic [IDX_W-1:0]    upd_idx,
  input  logic                upd_open,
  input  logic [ROW_BITS-1:0] upd_row
);
  logic [ENTRIES-1:0]               open_q;
  logic [ENTRIES-1:0][ROW_BITS-1:0] row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      row_q  <= '0;
    end else if (upd_en) begin
      open_q[upd_idx] <= upd_open;
      // Closing a bank keeps the stale row; only the open bit matters then.
      if (upd_open) row_q[upd_idx] <= upd_row;
    end
  end

  assign lkp_open = open_q[lkp_idx];
  assign lkp_row  = row_q[lkp_idx];
endmodule

// File: rtl/mem_cmd_scheduler.sv
// Turns one memory request at a time into PRECHARGE/ACTIVATE/READ/WRITE commands, tracking open rows per bank.
// Latency from accept: hit +1; closed +1 / +1+tRCD; conflict +1 / +1+tRP / +1+tRP+tRCD (plus burst-gap stalls).
// Backpressure: req_ready_out is high only in IDLE; the command side has no backpressure.
// Ports: clk_in, rst_N_in; request req_valid_in/req_ready_out/req_write_in/req_addr_in/req_data_in;
//        command cmd_valid_out/cmd_out/bank_group_out/bank_out/row_out/col_out/wdata_out; busy_out.
// MEM_CMD_SCHED_CLOSED_PAGE_EN: auto-precharge after every column command (closed-page policy).
module mem_cmd_scheduler
  import mem_ctrl_pkg::*;
#(
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_CYCLES       = 8,
  parameter int BANK_GROUPS        = 4,
  parameter int BANKS_PER_GROUP    = 2,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PADDR_BITS         = 19
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic                               req_write_in,
  input  logic [PADDR_BITS-1:0]              req_addr_in,
  input  logic [7:0][63:0]                   req_data_in,
  output logic                               cmd_valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [COL_BITS-1:0]                col_out,
  output logic [7:0][63:0]                   wdata_out,
  output logic                               busy_out
);
  localparam int BG_BITS = $clog2(BANK_GROUPS);
  localparam int BA_BITS = $clog2(BANKS_PER_GROUP);
  localparam int IDX_W   = BG_BITS + BA_BITS;
  localparam int TMR_W   = 8;
  localparam logic [TMR_W-1:0] ACT_WAIT = TMR_W'(ACTIVATION_LATENCY - 1);
  localparam logic [TMR_W-1:0] PRE_WAIT = TMR_W'(PRECHARGE_LATENCY - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(BURST_CYCLES - 1);

  sched_state_e        state_q, state_d;
  logic [TMR_W-1:0]    wait_q, wait_d, gap_q, gap_d;
  sched_req_t          req_q;
  logic                accept, issue, upd_en, upd_open, lkp_open;
  cmd_e                issue_cmd;
  logic [COL_BITS-1:0] p_col;
  logic [BA_BITS-1:0]  p_ba;
  logic [BG_BITS-1:0]  p_bg;
  logic [ROW_BITS-1:0] p_row, lkp_row;

  address_parser #(
    .PADDR_BITS(PADDR_BITS), .COL_BITS(COL_BITS), .BA_BITS(BA_BITS),
    .BG_BITS(BG_BITS), .ROW_BITS(ROW_BITS)
  ) u_parser (
    .addr(req_addr_in), .col(p_col), .ba(p_ba), .bg(p_bg), .row(p_row)
  );

  bank_state_table #(
    .ENTRIES(BANK_GROUPS * BANKS_PER_GROUP), .IDX_W(IDX_W), .ROW_BITS(ROW_BITS)
  ) u_banks (
    .clk(clk_in), .rst_n(rst_N_in),
    .lkp_idx({p_bg, p_ba}), .lkp_open(lkp_open), .lkp_row(lkp_row),
    .upd_en(upd_en), .upd_idx({req_q.bg, req_q.ba}), .upd_open(upd_open), .upd_row(req_q.row)
  );

`ifdef MEM_CMD_SCHED_CLOSED_PAGE_EN
  // Set once the auto-precharge has issued; AUTO_PRE then just counts out tRP.
  logic auto_wait_q, auto_wait_d;
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    gap_d     = (gap_q != '0) ? gap_q - 1'b1 : '0;
    accept    = 1'b0;
    issue     = 1'b0;
    issue_cmd = CMD_READ;
    upd_en    = 1'b0;
    upd_open  = 1'b0;
`ifdef MEM_CMD_SCHED_CLOSED_PAGE_EN
    auto_wait_d = auto_wait_q;
`endif
    unique case (state_q)
      S_IDLE: if (req_valid_in) begin
        accept = 1'b1;
        if (lkp_open && lkp_row == p_row) state_d = S_COL;
        else if (lkp_open)                state_d = S_PRE;
        else                              state_d = S_ACT;
      end
      S_PRE: if (gap_q == '0) begin
        issue     = 1'b1;
        issue_cmd = CMD_PRECHARGE;
        upd_en    = 1'b1;
        wait_d    = PRE_WAIT;
        state_d   = S_WAIT_PRE;
      end
      // Leaving on the decrement that reaches zero puts the next command
      // exactly LATENCY cycles after the one that loaded the counter.
      S_WAIT_PRE: begin
        wait_d = (wait_q != '0) ? wait_q - 1'b1 : '0;
        if (wait_q <= 1) state_d = S_ACT;
      end
      S_ACT: begin
        issue     = 1'b1;
        issue_cmd = CMD_ACTIVATE;
        upd_en    = 1'b1;
        upd_open  = 1'b1;
        wait_d    = ACT_WAIT;
        state_d   = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        wait_d = (wait_q != '0) ? wait_q - 1'b1 : '0;
        if (wait_q <= 1) state_d = S_COL;
      end
      S_COL: if (gap_q == '0) begin
        issue     = 1'b1;
        issue_cmd = req_q.write ? CMD_WRITE : CMD_READ;
        gap_d     = GAP_LOAD;
`ifdef MEM_CMD_SCHED_CLOSED_PAGE_EN
        auto_wait_d = 1'b0;
        state_d     = S_AUTO_PRE;
`else
        state_d     = S_IDLE;
`endif
      end
`ifdef MEM_CMD_SCHED_CLOSED_PAGE_EN
      S_AUTO_PRE: begin
        if (!auto_wait_q) begin
          if (gap_q == '0) begin
            issue       = 1'b1;
            issue_cmd   = CMD_PRECHARGE;
            upd_en      = 1'b1;
            wait_d      = PRE_WAIT;
            auto_wait_d = 1'b1;
          end
        end else begin
          wait_d = (wait_q != '0) ? wait_q - 1'b1 : '0;
          if (wait_q == '0) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q        <= S_IDLE;
      wait_q         <= '0;
      gap_q          <= '0;
      req_q          <= '0;
      cmd_valid_out  <= 1'b0;
      cmd_out        <= '0;
      bank_group_out <= '0;
      bank_out       <= '0;
      row_out        <= '0;
      col_out        <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      gap_q         <= gap_d;
      cmd_valid_out <= issue;
      if (accept) begin
        req_q <= '{write: req_write_in, row: p_row, col: p_col, bg: p_bg, ba: p_ba, data: req_data_in};
      end
      if (issue) begin
        cmd_out        <= issue_cmd;
        bank_group_out <= req_q.bg;
        bank_out       <= req_q.ba;
        row_out        <= req_q.row;
        col_out        <= req_q.col;
      end
    end
  end

`ifdef MEM_CMD_SCHED_CLOSED_PAGE_EN
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) auto_wait_q <= 1'b0;
    else           auto_wait_q <= auto_wait_d;
  end
`endif

  assign wdata_out     = req_q.data;
  assign req_ready_out = (state_q == S_IDLE);
  assign busy_out      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// Directed bench for mem_cmd_scheduler: command order, fields and issue cycles against hand-computed values.
// Cycle k is the interval after the k-th rising edge; the accept edge of a request is its cycle 0.
// Build with MEM_CMD_SCHED_CLOSED_PAGE_EN defined to exercise the closed-page sequence instead.
module tb_mem_cmd_scheduler;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [18:0]      req_addr = '0;
  logic [7:0][63:0] req_data = '0;
  logic             cmd_valid;
  logic [2:0]       cmd;
  logic [1:0]       bg;
  logic             ba;
  logic [7:0]       row;
  logic [3:0]       col;
  logic [7:0][63:0] wdata;
  logic             busy;

  mem_cmd_scheduler dut (
    .clk_in(clk), .rst_N_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .req_write_in(req_write),
    .req_addr_in(req_addr), .req_data_in(req_data),
    .cmd_valid_out(cmd_valid), .cmd_out(cmd), .bank_group_out(bg), .bank_out(ba),
    .row_out(row), .col_out(col), .wdata_out(wdata), .busy_out(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
    logic [1:0] bg;
    logic       ba;
    logic [7:0] row;
    logic [3:0] col;
  } rec_t;
  rec_t mon_q[$];

  always @(negedge clk)
    if (rst_n && cmd_valid) mon_q.push_back('{cyc, cmd, bg, ba, row, col});

  int n_chk = 0;
  int n_err = 0;

  localparam int RD = 0, WR = 1, ACT = 2, PRE = 3;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [18:0] addr, input logic [7:0][63:0] data,
                      output int acc);
    int b = 0;
    while (!req_ready && b < 100) begin
      @(negedge clk); #1;
      b++;
    end
    chk("ready_before_send", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk); #1;
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_cmds(input string tag, input int n);
    for (int i = 0; i < 200 && mon_q.size() < n; i++) begin
      @(negedge clk); #1;
    end
    chk({tag, "_cmd_count"}, mon_q.size() >= n, 1'b1);
  endtask

  // row/col < 0 means the field carries no meaning for that command.
  task automatic expect_cmd(input string tag, input int c, input int g, input int k,
                            input int r, input int cl, input int at);
    rec_t e;
    chk({tag, "_seen"}, mon_q.size() != 0, 1'b1);
    if (mon_q.size() == 0) return;
    e = mon_q.pop_front();
    chk({tag, "_cmd"}, e.cmd, c);
    chk({tag, "_bg"},  e.bg,  g);
    chk({tag, "_ba"},  e.ba,  k);
    if (r >= 0)  chk({tag, "_row"}, e.row, r);
    if (cl >= 0) chk({tag, "_col"}, e.col, cl);
    chk({tag, "_cycle"}, e.cyc, at);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  int a, b, c, d;
  logic [7:0][63:0] pat;
  logic [7:0][63:0] zero_line;

  initial begin
    zero_line = '0;
    for (int i = 0; i < 8; i++) pat[i] = 64'hA5C3_0000_0000_0000 | 64'(i * 17 + 1);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_cmd",   cmd,       3'd0);
    chk("rst_row",   row,       8'd0);
    chk("rst_wdata", wdata,     zero_line);
    rst_n = 1'b1;
    @(negedge clk); #1;

`ifdef MEM_CMD_SCHED_CLOSED_PAGE_EN
    // Every access opens, reads and closes; tRP keeps the port closed afterwards.
    send(1'b0, 19'h923, zero_line, a);
    wait_cmds("cp1", 3);
    expect_cmd("cp1_act", ACT, 1, 0, 8'h12, -1, a + 1);
    expect_cmd("cp1_rd",  RD,  1, 0, 8'h12, 3,  a + 9);
    expect_cmd("cp1_pre", PRE, 1, 0, -1,    -1, a + 17);
    chk("cp1_ready_at_pre", req_ready, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("cp1_ready_pre_plus4", req_ready, 1'b0);
    @(negedge clk); #1;
    chk("cp1_ready_pre_plus5", req_ready, 1'b1);
    send(1'b0, 19'h923, zero_line, b);
    chk("cp2_accept", b, a + 23);
    wait_cmds("cp2", 3);
    expect_cmd("cp2_act", ACT, 1, 0, 8'h12, -1, b + 1);
    expect_cmd("cp2_rd",  RD,  1, 0, 8'h12, 3,  b + 9);
    expect_cmd("cp2_pre", PRE, 1, 0, -1,    -1, b + 17);
`else
    // Closed bank: ACTIVATE at +1, READ at +1+tRCD.
    send(1'b0, 19'h923, zero_line, a);
    wait_cmds("t1", 2);
    expect_cmd("t1_act", ACT, 1, 0, 8'h12, -1, a + 1);
    expect_cmd("t1_rd",  RD,  1, 0, 8'h12, 3,  a + 9);

    // Row hit right behind it: stalled until the burst gap from cycle a+9 drains.
    send(1'b0, 19'h925, zero_line, b);
    chk("t2_accept", b, a + 10);
    wait_cmds("t2", 1);
    expect_cmd("t2_rd", RD, 1, 0, 8'h12, 5, a + 17);

    // Other bank: ACTIVATE without PRECHARGE; the first bank stays open.
    send(1'b0, 19'h950, zero_line, b);
    wait_cmds("t3", 2);
    expect_cmd("t3_act", ACT, 2, 1, 8'h12, -1, b + 1);
    expect_cmd("t3_rd",  RD,  2, 1, 8'h12, 0,  b + 9);
    send(1'b0, 19'h923, zero_line, c);
    wait_cmds("t4", 1);
    expect_cmd("t4_hit_rd", RD, 1, 0, 8'h12, 3, b + 17);

    // Conflict write: PRECHARGE gated by the burst gap, then tRP, then tRCD.
    send(1'b1, 19'h1A23, pat, d);
    wait_cmds("t5", 3);
    expect_cmd("t5_pre", PRE, 1, 0, -1,    -1, b + 25);
    expect_cmd("t5_act", ACT, 1, 0, 8'h34, -1, b + 30);
    expect_cmd("t5_wr",  WR,  1, 0, 8'h34, 3,  b + 38);
    chk("t5_wdata", wdata, pat);

    // Reset in the middle of WAIT_ACT aborts the request and closes every bank.
    send(1'b0, 19'h903, zero_line, a);
    wait_cmds("t6", 1);
    expect_cmd("t6_act", ACT, 0, 0, 8'h12, -1, a + 1);
    repeat (3) @(negedge clk);
    chk("t6_busy_before_rst", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", cmd_valid, 1'b0);
    chk("t6_rst_ready", req_ready, 1'b1);
    chk("t6_rst_busy",  busy,      1'b0);
    chk("t6_rst_cmd",   cmd,       3'd0);
    chk("t6_rst_row",   row,       8'd0);
    chk("t6_rst_wdata", wdata,     zero_line);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("t6_no_cmd_after_abort", mon_q.size(), 0);
    send(1'b0, 19'h923, zero_line, b);
    wait_cmds("t7", 2);
    expect_cmd("t7_act", ACT, 1, 0, 8'h12, -1, b + 1);
    expect_cmd("t7_rd",  RD,  1, 0, 8'h12, 3,  b + 9);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
